uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Pop-side bus of the UART receive FIFO: head word, its error flags and the valid/ready pair.
// The receiver drives the master modport; the consumer (MMIO/loader) uses the slave modport.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rdata;
    logic                 rdata_valid;
    logic                 rdata_ready;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rdata,
        output rdata_valid,
        output frame_err,
        output parity_err,
        input  rdata_ready
    );

    modport slave (
        input  rdata,
        input  rdata_valid,
        input  frame_err,
        input  parity_err,
        output rdata_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with input synchroniser, false-start rejection, parity/stop checks
// and a first-word fall-through RX FIFO whose entries carry their own error flags.
module uart_rx_fifo #(
    parameter int FMAX_MHz   = 27,
    parameter int BaudRate   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           uart_rx,
    uart_rx_fifo_if.master rxBus,
    output logic           overrun,
    output logic           busy
);

`ifdef FAST_UART
    localparam int DELAY_FRAMES = 2;
`else
    localparam int DELAY_FRAMES = FMAX_MHz * 1000000 / BaudRate;
`endif
    localparam int HALF  = DELAY_FRAMES / 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_BITS + 2;

    localparam logic [31:0]    FULL_LIM  = 32'(DELAY_FRAMES);
    localparam logic [31:0]    HALF_LIM  = 32'(HALF);
    localparam logic [31:0]    CNT_ONE   = 32'd1;
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_PUSH,
        S_BRK
    } rxStateT;

    rxStateT              state;
    logic                 rxMeta;
    logic                 rxSync;
    logic [31:0]          counter;
    logic [2:0]           bitIdx;
    logic                 stopIdx;
    logic [DATA_BITS-1:0] shiftData;
    logic                 parityBad;
    logic                 frameBad;

    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0]       wrPtr;
    logic [PTR_W:0]       rdPtr;
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic                 pushEn;
    logic                 popEn;
    logic [ENT_W-1:0]     head;
    logic                 sampleTick;
    logic                 halfTick;

    // Both sync stages reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= uart_rx;
            rxSync <= rxMeta;
        end
    end

    assign sampleTick = (counter + CNT_ONE) == FULL_LIM;
    assign halfTick   = (counter + CNT_ONE) == HALF_LIM;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            counter   <= '0;
            bitIdx    <= '0;
            stopIdx   <= 1'b0;
            shiftData <= '0;
            parityBad <= 1'b0;
            frameBad  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxSync) begin
                        state   <= S_START;
                        counter <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (halfTick) begin
                        counter <= '0;
                        if (rxSync) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            bitIdx    <= '0;
                            parityBad <= 1'b0;
                            frameBad  <= 1'b0;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (sampleTick) begin
                        counter   <= '0;
                        // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
                        shiftData <= {rxSync, shiftData[DATA_BITS-1:1]};
                        if (bitIdx == LAST_BIT) begin
                            state   <= (PARITY != 0) ? S_PAR : S_STOP;
                            stopIdx <= 1'b0;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                S_PAR: begin
                    if (sampleTick) begin
                        counter   <= '0;
                        parityBad <= ((^shiftData) ^ rxSync) != (PARITY == 1);
                        state     <= S_STOP;
                        stopIdx   <= 1'b0;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (sampleTick) begin
                        counter <= '0;
                        if (!rxSync) begin
                            frameBad <= 1'b1;
                        end
                        if (stopIdx == LAST_STOP) begin
                            state <= S_PUSH;
                        end else begin
                            stopIdx <= 1'b1;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                S_PUSH: begin
                    overrun <= fifoFull;
                    if (rxSync) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_BRK;
                    end
                end
                S_BRK: begin
                    if (rxSync) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Extra pointer MSB distinguishes full from empty; full is judged before any same-cycle pop.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                       (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign pushEn    = (state == S_PUSH) && !fifoFull;
    assign popEn     = !fifoEmpty && rxBus.rdata_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wrPtr[PTR_W-1:0]] <= {parityBad, frameBad, shiftData};
        end
    end

    // Head is forced to zero while empty so the outputs read 0 out of reset.
    assign head              = mem[rdPtr[PTR_W-1:0]];
    assign rxBus.rdata_valid = !fifoEmpty;
    assign rxBus.rdata       = fifoEmpty ? '0 : head[DATA_BITS-1:0];
    assign rxBus.frame_err   = !fifoEmpty && head[DATA_BITS];
    assign rxBus.parity_err  = !fifoEmpty && head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three configurations (8N1, 7E1, 8N2) checked every cycle against a
// queue-based frame model, plus literal expectations at key points.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int BIT_T = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rxLine [3];
    logic rdy [3];
    logic vld [3];
    logic [7:0] dat [3];
    logic ferr [3];
    logic perr [3];
    logic ovr [3];
    logic bsy [3];

    int cfgDb   [3] = '{8, 7, 8};
    int cfgPar  [3] = '{0, 2, 0};
    int cfgStop [3] = '{1, 1, 2};

    int cyc = 0;
    logic rstAtEdge = 1'b1;
    int nVec = 0;
    int nFail = 0;

    // Model state: one pending frame per line, expected FIFO contents per DUT.
    logic       pendValid [3];
    int         pendCyc [3];
    logic [9:0] pendEnt [3];
    logic [9:0] mq [3][$];
    logic       popPend [3];
    logic [7:0] popLog0 [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rstAtEdge <= !reset_n;
    end

    uart_rx_fifo_if #(.DATA_BITS(8)) ifA ();
    uart_rx_fifo_if #(.DATA_BITS(7)) ifB ();
    uart_rx_fifo_if #(.DATA_BITS(8)) ifC ();

    uart_rx_fifo #(.FMAX_MHz(1), .BaudRate(125000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutA (
        .clk(clk), .reset_n(reset_n), .uart_rx(rxLine[0]), .rxBus(ifA),
        .overrun(ovr[0]), .busy(bsy[0]));
    uart_rx_fifo #(.FMAX_MHz(1), .BaudRate(125000), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutB (
        .clk(clk), .reset_n(reset_n), .uart_rx(rxLine[1]), .rxBus(ifB),
        .overrun(ovr[1]), .busy(bsy[1]));
    uart_rx_fifo #(.FMAX_MHz(1), .BaudRate(125000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dutC (
        .clk(clk), .reset_n(reset_n), .uart_rx(rxLine[2]), .rxBus(ifC),
        .overrun(ovr[2]), .busy(bsy[2]));

    assign ifA.rdata_ready = rdy[0];
    assign ifB.rdata_ready = rdy[1];
    assign ifC.rdata_ready = rdy[2];
    assign vld[0] = ifA.rdata_valid;
    assign vld[1] = ifB.rdata_valid;
    assign vld[2] = ifC.rdata_valid;
    assign dat[0] = ifA.rdata;
    assign dat[1] = {1'b0, ifB.rdata};
    assign dat[2] = ifC.rdata;
    assign ferr[0] = ifA.frame_err;
    assign ferr[1] = ifB.frame_err;
    assign ferr[2] = ifC.frame_err;
    assign perr[0] = ifA.parity_err;
    assign perr[1] = ifB.parity_err;
    assign perr[2] = ifC.parity_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model; full is judged before the pop of the same edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic arrive;
            logic fullB;
            logic expOvr;
            logic [9:0] ent;
            expOvr = 1'b0;
            if (rstAtEdge) begin
                mq[d].delete();
                popPend[d] = 1'b0;
            end else begin
                arrive = pendValid[d] && (cyc == pendCyc[d]);
                fullB  = (mq[d].size() == DEPTH);
                expOvr = arrive && fullB;
                if (popPend[d]) begin
                    ent = mq[d].pop_front();
                    if (d == 0) popLog0.push_back(ent[7:0]);
                    $display("dut%0d pop data=%02h ferr=%0b perr=%0b", d, ent[7:0], ent[8], ent[9]);
                end
                if (arrive && !fullB) mq[d].push_back(pendEnt[d]);
            end
            check($sformatf("dut%0d valid", d), 32'(vld[d]), 32'(mq[d].size() > 0));
            check($sformatf("dut%0d overrun", d), 32'(ovr[d]), 32'(expOvr));
            if (mq[d].size() > 0) begin
                ent = mq[d][0];
                check($sformatf("dut%0d rdata", d), 32'(dat[d]), 32'(ent[7:0]));
                check($sformatf("dut%0d frame_err", d), 32'(ferr[d]), 32'(ent[8]));
                check($sformatf("dut%0d parity_err", d), 32'(perr[d]), 32'(ent[9]));
            end
            popPend[d] = (mq[d].size() > 0) && rdy[d];
        end
    end

    task automatic driveBit(input int d, input logic b);
        rxLine[d] = b;
        repeat (BIT_T) @(posedge clk);
        #1;
    endtask

    // Sends one frame; the expected entry becomes visible 8*nbits cycles after the start edge.
    task automatic sendFrame(input int d, input logic [7:0] data, input logic parBit,
                             input logic s1, input logic s2);
        int nb;
        int c0;
        logic [7:0] dm;
        logic ones;
        logic pb;
        logic fb;
        @(posedge clk);
        #1;
        c0 = cyc;
        nb = 1 + cfgDb[d] + ((cfgPar[d] != 0) ? 1 : 0) + cfgStop[d];
        dm = data & 8'((1 << cfgDb[d]) - 1);
        ones = ^dm;
        if (cfgPar[d] == 0) pb = 1'b0;
        else if (cfgPar[d] == 2) pb = (ones ^ parBit) != 1'b0;
        else pb = (ones ^ parBit) != 1'b1;
        fb = !s1 || (cfgStop[d] == 2 && !s2);
        pendEnt[d] = {pb, fb, dm};
        pendCyc[d] = c0 + BIT_T * nb;
        pendValid[d] = 1'b1;
        $display("dut%0d send data=%02h par=%0b stop=%0b%0b expect ferr=%0b perr=%0b",
                 d, dm, parBit, s1, s2, fb, pb);
        driveBit(d, 1'b0);
        for (int i = 0; i < cfgDb[d]; i++) driveBit(d, dm[i]);
        if (cfgPar[d] != 0) driveBit(d, parBit);
        driveBit(d, s1);
        if (cfgStop[d] == 2) driveBit(d, s2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        for (int d = 0; d < 3; d++) begin
            rxLine[d] = 1'b1;
            rdy[d] = 1'b1;
            pendValid[d] = 1'b0;
            pendCyc[d] = 0;
            pendEnt[d] = '0;
            popPend[d] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset valid", 32'(vld[0]), 32'd0);
        check("reset busy", 32'(bsy[0]), 32'd0);
        check("reset overrun", 32'(ovr[0]), 32'd0);

        // 8N1, ready high: word visible exactly in the cycle the model predicts
        sendFrame(0, 8'h55, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("8N1 first valid", 32'(vld[0]), 32'd1);
        check("8N1 first data", 32'(dat[0]), 32'h55);
        sendFrame(0, 8'hA3, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("8N1 second data", 32'(dat[0]), 32'hA3);
        check("8N1 second flags", 32'({ferr[0], perr[0]}), 32'd0);

        // 7E1: 0x41 has two ones, so parity bit 0 is good and 1 is bad
        sendFrame(1, 8'h41, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("7E1 good parity_err", 32'(perr[1]), 32'd0);
        sendFrame(1, 8'h41, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("7E1 bad data", 32'(dat[1]), 32'h41);
        check("7E1 bad parity_err", 32'(perr[1]), 32'd1);

        // 8N2 with low second stop bit, line then stuck low
        sendFrame(2, 8'h3C, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("8N2 data", 32'(dat[2]), 32'h3C);
        check("8N2 frame_err", 32'(ferr[2]), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("break busy", 32'(bsy[2]), 32'd1);
        rxLine[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("break released busy", 32'(bsy[2]), 32'd0);

        // 3-cycle glitch on idle line
        @(posedge clk);
        #1;
        rxLine[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxLine[0] = 1'b1;
        @(negedge clk);
        check("glitch busy high", 32'(bsy[0]), 32'd1);
        repeat (8) @(negedge clk);
        check("glitch busy low", 32'(bsy[0]), 32'd0);
        check("glitch fifo empty", 32'(vld[0]), 32'd0);

        // Overrun: five frames with the consumer stalled
        rdy[0] = 1'b0;
        for (int k = 1; k <= 5; k++) sendFrame(0, 8'(k), 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("overrun pulse", 32'(ovr[0]), 32'd1);
        check("overrun head", 32'(dat[0]), 32'h01);
        @(negedge clk);
        check("overrun one cycle", 32'(ovr[0]), 32'd0);
        n0 = popLog0.size();
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain count", 32'(popLog0.size() - n0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (n0 + k < popLog0.size())
                check($sformatf("drain order %0d", k), 32'(popLog0[n0 + k]), 32'(k + 1));
        end

        // Reset in the middle of 0x7E's data bits
        @(posedge clk);
        #1;
        driveBit(0, 1'b0);
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        driveBit(0, 1'b1);
        check("mid-frame busy", 32'(bsy[0]), 32'd1);
        reset_n = 1'b0;
        rxLine[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("post-reset valid", 32'(vld[0]), 32'd0);
        check("post-reset busy", 32'(bsy[0]), 32'd0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
